generador_tonos_poli: RTL and testbench
=======================================

Name: generador_tonos_poli

Overview:
- Parametrised successor of the single-voice music-box tone stage: maps N_TECLAS key inputs to up to N_CANALES simultaneous square-wave tones, with octave selection.
- Retunes only at period boundaries, so outputs are glitch-free.
- Sits between the key inputs and the audio pins; clk_out keeps the single-voice output for the existing top level.

Parameters:
- N_TECLAS, 7, number of key inputs (1..16).
- N_CANALES, 2, number of tone channels (1..4).
- ANCHO_DIV, 21, width of the half-period divisor and counter.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low reset.
- teclas  input  N_TECLAS  raw key levels, asynchronous to clk.
- octava  input  2  octave shift; 0 = base octave (C4..B4), n divides the half period by 2^n.
- salida_canales  output  N_CANALES  per-channel square wave.
- canal_activo  output  N_CANALES  high while the channel is producing a tone.
- clk_out  output  1  equals salida_canales[0].

Behaviour:
- Reset is asynchronous and active-low. While reset=0, all outputs are 0, all counters are 0 and the synchroniser flops are 0.
- Input synchronisation: teclas and octava pass through 2 flops. A key change is visible to the assignment logic 2 cycles after the edge, and in channel state 3 cycles after.
- Assignment (combinational on the synced keys): channel c takes the (c+1)-th lowest-index asserted key. If fewer keys are pressed than channels, the remaining channels request idle. Keys beyond N_CANALES are ignored.
- Divisor: div = TABLA_DIV[key] >> octava. If div < 2, use 2. The key index wraps modulo 7 into the table, so key 7 maps to table entry 0.
- Channel state machine (per channel):
  - IDLE: out=0, cnt=0, activo=0. On a request, load div into div_act, set activo=1, go to ALTO_PEND. The first rising edge of out occurs div_act cycles after the load.
  - SONANDO: cnt counts 0..div_act-1. At div_act-1, cnt resets to 0 and out toggles.
  - Boundary = cnt==div_act-1 while out==1, i.e. the falling edge that ends a period.
  - Only at a boundary: the new request's div replaces div_act (including octave changes), or, if the request is idle, the channel goes to IDLE with out=0 and activo=0.
  - Requests that change and then revert between boundaries have no effect. Every emitted period is complete: high and low phases are each exactly div_act cycles.
  - ALTO_PEND is SONANDO with out=0 before the first toggle. A request that drops here returns the channel to IDLE immediately; no partial pulse is emitted.
- Simultaneous events: a new key and an octave change at the same boundary are applied together. A key released on one channel while others are still held re-shuffles the assignments; each channel follows its new request at its own next boundary.
- Reset mid-tone drops every output to 0 immediately, with no completion of the current period.
- The counter never exceeds div_act-1 and div_act never exceeds 2^ANCHO_DIV-1. An elaboration check requires the largest table entry to fit in ANCHO_DIV.

Decomposition:
- Package tonos_pkg holds:
  - TABLA_DIV[0..6], half-period counts at 50 MHz: 95555, 85132, 75844, 71586, 63776, 56818, 50620 (C4..B4).
  - DIV_MIN = 2.
  - Channel state enum {IDLE, ALTO_PEND, SONANDO}.
- Sub-module canal_tono, one instance per channel via generate. It contains the counter, the state machine and the boundary update. Inputs: request valid and div. Outputs: out and activo.
- The top level holds the synchroniser, the k-th-set-bit assignment logic and the octave shift.

Test Plan:
- Reset held 100 ns, teclas=0000001, octava=0 → clk_out period 3,822,200 ns, high time 1,911,100 ns, canal_activo=01.
- teclas=0100000 (A4), octava=1 → period 1,136,360 ns (div 28409); octava set to 3 mid-tone → the next complete period after the boundary is 284,080 ns, with no short pulse.
- teclas=1000101 → channel 0 on key 0 (3,822,200 ns), channel 1 on key 2 (3,033,760 ns), key 6 ignored; then release key 0 → channel 0 moves to key 2 and channel 1 finishes its period and goes idle (canal_activo=01).
- A key is pressed and released within 10 µs while idle → no pulse on any output and canal_activo stays 0. Release during SONANDO → the high and low phases of the final period are both full length, then out=0.
- Assert reset=0 mid high phase → salida_canales=0 and canal_activo=0 within the same cycle. Release reset with the key held → the first rising edge occurs 3 + 95555 cycles later.

Source files
------------

// File: rtl/tonos_pkg.sv
// Shared definitions for the polyphonic tone generator.
//   TABLA_DIV  half-period counts at 50 MHz for C4..B4
//   DIV_MIN    smallest usable half period (after the octave shift)
//   estado_t   per-channel state
//   div_tecla  key index + octave -> half-period divisor
package tonos_pkg;

    localparam int          N_TABLA   = 7;
    localparam int unsigned TABLA_DIV [N_TABLA] =
        '{95555, 85132, 75844, 71586, 63776, 56818, 50620};
    localparam int unsigned TABLA_MAX = 95555;
    localparam int unsigned DIV_MIN   = 2;

    typedef enum logic [1:0] {
        IDLE,
        ALTO_PEND,
        SONANDO
    } estado_t;

    // Keys past the seventh wrap around onto the same seven notes.
    function automatic int unsigned div_tecla(input logic [3:0] tecla,
                                              input logic [1:0] oct);
        logic [3:0]  idx;
        int unsigned d;
        idx = tecla;
        if (idx >= 4'd7) idx = idx - 4'd7;
        if (idx >= 4'd7) idx = idx - 4'd7;
        d = TABLA_DIV[idx[2:0]] >> oct;
        if (d < DIV_MIN) d = DIV_MIN;
        return d;
    endfunction

endpackage

// File: rtl/canal_tono.sv
// One square-wave tone channel.
//   clk, reset  system clock, async active-low reset
//   pet_vld     a key is assigned to this channel
//   pet_div     half-period of the requested tone
//   salida      square wave
//   activo      high while a tone is being produced
// A period is a low phase followed by a high phase; the requested divisor
// is only sampled at the falling edge that closes a period, so every
// emitted period is whole and retuning never produces a short pulse.
module canal_tono
    import tonos_pkg::*;
#(
    parameter int ANCHO_DIV = 21
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pet_vld,
    input  logic [ANCHO_DIV-1:0] pet_div,
    output logic                 salida,
    output logic                 activo
);

    estado_t              estado_q, estado_d;
    logic [ANCHO_DIV-1:0] cnt_q, cnt_d;
    logic [ANCHO_DIV-1:0] div_q, div_d;
    logic                 out_q, out_d;
    logic                 fin_fase;

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        out_d    = out_q;
        fin_fase = (cnt_q == div_q - 1'b1);
        case (estado_q)
            IDLE: begin
                if (pet_vld) begin
                    estado_d = ALTO_PEND;
                    div_d    = pet_div;
                    cnt_d    = '0;
                    out_d    = 1'b0;
                end
            end
            // First low phase: a released key aborts before any pulse.
            ALTO_PEND: begin
                if (!pet_vld) begin
                    estado_d = IDLE;
                    cnt_d    = '0;
                    out_d    = 1'b0;
                end else if (fin_fase) begin
                    estado_d = SONANDO;
                    cnt_d    = '0;
                    out_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SONANDO: begin
                if (fin_fase) begin
                    cnt_d = '0;
                    if (out_q) begin
                        // Period boundary: retune or stop.
                        out_d = 1'b0;
                        if (pet_vld) div_d    = pet_div;
                        else         estado_d = IDLE;
                    end else begin
                        out_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                estado_d = IDLE;
                cnt_d    = '0;
                out_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q <= IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            out_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            out_q    <= out_d;
        end
    end

    assign salida = out_q;
    assign activo = (estado_q != IDLE);

endmodule

// File: rtl/generador_tonos_poli.sv
// Polyphonic square-wave tone generator.
//   clk             system clock (50 MHz)
//   reset           async active-low reset
//   teclas          raw key levels (asynchronous)
//   octava          octave shift, halves the half period per step
//   salida_canales  one square wave per channel
//   canal_activo    channel is producing a tone
//   clk_out         channel 0 output, for the single-voice top level
// Channel c plays the (c+1)-th lowest pressed key; extra keys are dropped.
module generador_tonos_poli
    import tonos_pkg::*;
#(
    parameter int N_TECLAS  = 7,
    parameter int N_CANALES = 2,
    parameter int ANCHO_DIV = 21
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_TECLAS-1:0]  teclas,
    input  logic [1:0]           octava,
    output logic [N_CANALES-1:0] salida_canales,
    output logic [N_CANALES-1:0] canal_activo,
    output logic                 clk_out
);

    if ((TABLA_MAX >> ANCHO_DIV) != 0) begin : g_chk_ancho
        $error("ANCHO_DIV too narrow for the largest divisor");
    end
    if (N_TECLAS < 1 || N_TECLAS > 16) begin : g_chk_teclas
        $error("N_TECLAS must be 1..16");
    end
    if (N_CANALES < 1 || N_CANALES > 4) begin : g_chk_canales
        $error("N_CANALES must be 1..4");
    end

    logic [N_TECLAS-1:0] teclas_s1_q, teclas_s1_d;
    logic [N_TECLAS-1:0] teclas_s2_q, teclas_s2_d;
    logic [1:0]          oct_s1_q, oct_s1_d;
    logic [1:0]          oct_s2_q, oct_s2_d;

    logic [N_CANALES-1:0]                pet_vld;
    logic [N_CANALES-1:0][ANCHO_DIV-1:0] pet_div;

    always_comb begin
        teclas_s1_d = teclas;
        teclas_s2_d = teclas_s1_q;
        oct_s1_d    = octava;
        oct_s2_d    = oct_s1_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            teclas_s1_q <= '0;
            teclas_s2_q <= '0;
            oct_s1_q    <= '0;
            oct_s2_q    <= '0;
        end else begin
            teclas_s1_q <= teclas_s1_d;
            teclas_s2_q <= teclas_s2_d;
            oct_s1_q    <= oct_s1_d;
            oct_s2_q    <= oct_s2_d;
        end
    end

    // k-th set bit: walk keys low to high, handing each pressed key to the
    // channel whose index equals the number of pressed keys seen so far.
    always_comb begin
        int n_pulsadas;
        pet_vld    = '0;
        pet_div    = '0;
        n_pulsadas = 0;
        for (int k = 0; k < N_TECLAS; k++) begin
            if (teclas_s2_q[k]) begin
                for (int c = 0; c < N_CANALES; c++) begin
                    if (n_pulsadas == c) begin
                        pet_vld[c] = 1'b1;
                        pet_div[c] = ANCHO_DIV'(div_tecla(4'(k), oct_s2_q));
                    end
                end
                n_pulsadas = n_pulsadas + 1;
            end
        end
    end

    for (genvar c = 0; c < N_CANALES; c++) begin : g_canal
        canal_tono #(
            .ANCHO_DIV(ANCHO_DIV)
        ) u_canal (
            .clk    (clk),
            .reset  (reset),
            .pet_vld(pet_vld[c]),
            .pet_div(pet_div[c]),
            .salida (salida_canales[c]),
            .activo (canal_activo[c])
        );
    end

    assign clk_out = salida_canales[0];

endmodule

// File: tb/tb_generador_tonos_poli.sv
// Directed bench for generador_tonos_poli (7 keys, 2 channels).
// Octave 3 is used for every timed case to keep run length short;
// half periods there are table >> 3.
module tb_generador_tonos_poli;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] teclas = '0;
    logic [1:0] octava = '0;
    logic [1:0] salida;
    logic [1:0] activo;
    logic       clk_out;

    always #10 clk = ~clk;

    generador_tonos_poli #(
        .N_TECLAS (7),
        .N_CANALES(2),
        .ANCHO_DIV(21)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .teclas        (teclas),
        .octava        (octava),
        .salida_canales(salida),
        .canal_activo  (activo),
        .clk_out       (clk_out)
    );

    int ciclo = 0;
    always @(posedge clk) ciclo <= ciclo + 1;

    // Edge recorder: counts and last cycle of each rise/fall per channel.
    int   n_sube [2] = '{0, 0};
    int   n_baja [2] = '{0, 0};
    int   t_sube [2] = '{0, 0};
    int   t_baja [2] = '{0, 0};
    int   err_espejo = 0;
    logic [1:0] prev = '0;
    always @(negedge clk) begin
        if (salida[0] && !prev[0]) begin n_sube[0] = n_sube[0] + 1; t_sube[0] = ciclo; end
        if (!salida[0] && prev[0]) begin n_baja[0] = n_baja[0] + 1; t_baja[0] = ciclo; end
        if (salida[1] && !prev[1]) begin n_sube[1] = n_sube[1] + 1; t_sube[1] = ciclo; end
        if (!salida[1] && prev[1]) begin n_baja[1] = n_baja[1] + 1; t_baja[1] = ciclo; end
        if (clk_out !== salida[0]) err_espejo = err_espejo + 1;
        prev = salida;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nombre, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nombre, got, exp);
        end
    endtask

    // Waits for the next rise (sube=1) or fall on a channel; t=-1 on timeout.
    task automatic esperar(input bit ch, input bit sube, input int limite, output int t);
        int n0;
        n0 = sube ? n_sube[ch] : n_baja[ch];
        t  = -1;
        for (int i = 0; i < limite; i++) begin
            @(negedge clk); #1;
            if ((sube ? n_sube[ch] : n_baja[ch]) != n0) begin
                t = sube ? t_sube[ch] : t_baja[ch];
                break;
            end
        end
    endtask

    task automatic pulso_reset();
        teclas = '0;
        octava = '0;
        reset  = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [6:0] teclas;
        logic [1:0] oct;
        logic [1:0] act;
        int         lat0;     // cycles from key change to first rise, 0 = none
        int         lat1;
        int         ventana;  // observation window in cycles
    } vec_t;

    vec_t tabla [5];

    initial begin
        int t0, t, n0, n1, tr1, tr0;

        // Half periods at octave 3: key0 11944, key2 9480, key5 7102, key6 6327.
        tabla[0] = '{7'b0000000, 2'd0, 2'b00, 0,     0,    300};
        tabla[1] = '{7'b0000010, 2'd0, 2'b01, 0,     0,    20};
        tabla[2] = '{7'b0011000, 2'd1, 2'b11, 0,     0,    20};
        tabla[3] = '{7'b1111111, 2'd3, 2'b11, 0,     0,    20};
        tabla[4] = '{7'b1000101, 2'd3, 2'b11, 11947, 9483, 12000};

        // Reset state, held 100 ns.
        #50;
        chk("reset_salida",  int'(salida),  0);
        chk("reset_activo",  int'(activo),  0);
        chk("reset_clk_out", int'(clk_out), 0);
        #50;

        for (int v = 0; v < 5; v++) begin
            pulso_reset();
            teclas = tabla[v].teclas;
            octava = tabla[v].oct;
            t0 = ciclo;
            n0 = n_sube[0];
            n1 = n_sube[1];
            repeat (4) @(posedge clk);
            #1 chk($sformatf("v%0d_activo", v), int'(activo), int'(tabla[v].act));
            while (ciclo < t0 + tabla[v].ventana) begin
                @(negedge clk); #1;
            end
            chk($sformatf("v%0d_lat0", v), (n_sube[0] != n0) ? t_sube[0] - t0 : 0, tabla[v].lat0);
            chk($sformatf("v%0d_lat1", v), (n_sube[1] != n1) ? t_sube[1] - t0 : 0, tabla[v].lat1);
        end

        // Key tapped for 10 us while idle: no pulse, channel drops back.
        pulso_reset();
        octava = 2'd3;
        teclas = 7'b1000000;
        t0 = ciclo;
        n0 = n_sube[0];
        n1 = n_sube[1];
        repeat (500) @(posedge clk);
        #1 chk("tap_activo_on", int'(activo), 1);
        teclas = '0;
        repeat (4) @(posedge clk);
        #1 chk("tap_activo_off", int'(activo), 0);
        while (ciclo < t0 + 6600) begin
            @(negedge clk); #1;
        end
        chk("tap_sin_pulso0", n_sube[0] - n0, 0);
        chk("tap_sin_pulso1", n_sube[1] - n1, 0);

        // Keys 5+6, then release key 5 during ch1's first high phase.
        pulso_reset();
        octava = 2'd3;
        teclas = 7'b1100000;
        t0 = ciclo;
        n0 = n_sube[0];
        esperar(1'b1, 1'b1, 6400, tr1);
        chk("reparto_lat1", tr1 - t0, 6330);
        teclas = 7'b1000000;
        n1 = n_sube[1];
        esperar(1'b1, 1'b0, 6500, t);
        chk("suelta_alto1", t - tr1, 6327);
        chk("suelta_activo", int'(activo), 1);
        chk("reparto_lat0", (n_sube[0] != n0) ? t_sube[0] - t0 : -1, 7105);
        tr0 = t_sube[0];
        esperar(1'b0, 1'b0, 2000, t);
        chk("reparto_alto0", t - tr0, 7102);
        tr0 = t;
        esperar(1'b0, 1'b1, 6500, t);
        chk("reparto_bajo0", t - tr0, 6327);
        chk("suelta_sin_pulso1", n_sube[1] - n1, 0);

        // Reset in the high phase, then release with key 6 still held.
        repeat (100) @(posedge clk);
        #5 reset = 1'b0;
        #1;
        chk("rst_mid_salida", int'(salida), 0);
        chk("rst_mid_activo", int'(activo), 0);
        chk("rst_mid_clk_out", int'(clk_out), 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        t0 = ciclo;
        esperar(1'b0, 1'b1, 6400, t);
        chk("rst_rel_lat0", t - t0, 6330);

        // Octave change during the high phase: current period finishes,
        // then the new half period applies.
        pulso_reset();
        octava = 2'd3;
        teclas = 7'b1000000;
        t0 = ciclo;
        esperar(1'b0, 1'b1, 6400, t);
        chk("oct_lat0", t - t0, 6330);
        octava = 2'd2;
        tr0 = t;
        esperar(1'b0, 1'b0, 6500, t);
        chk("oct_alto_viejo", t - tr0, 6327);
        tr0 = t;
        esperar(1'b0, 1'b1, 13000, t);
        chk("oct_bajo_nuevo", t - tr0, 12655);
        chk("oct_activo", int'(activo), 1);

        chk("clk_out_espejo", err_espejo, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
